// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with simultaneous read/write,
// an occupancy count, zero-lag status flags and sticky error flags.
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst          - asynchronous, active-high reset
//   mode[1:0]    - command: 00 idle, 01 write, 10 read, 11 read+write
//   datain       - write data, stored when a write is accepted
//   clr_err      - clears overflow/underflow (a same-cycle error wins)
//   dataout      - registered read data; holds between reads
//   valid_out    - high for one cycle after each accepted read
//   empty/full   - count == 0 / count == DEPTH
//   almost_empty - count <= AE_LEVEL
//   almost_full  - count >= AF_LEVEL
//   count        - current occupancy, 0..DEPTH
//   overflow     - sticky: a write was rejected
//   underflow    - sticky: a read was rejected
module fifo_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 5,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] datain,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dataout,
  output logic             valid_out,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;

  logic rd_req;
  logic wr_req;
  logic rd_ok;
  logic wr_ok;

  assign rd_req = mode[1];
  assign wr_req = mode[0];
  assign rd_ok  = rd_req && (count != '0);
  // A full FIFO can still take a write when a read frees a slot this cycle.
  assign wr_ok  = wr_req && ((count != FULL_CNT) || rd_ok);

  // Flags decode the registered count directly, so they never lag it.
  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_empty = (int'(count) <= AE_LEVEL);
  assign almost_full  = (int'(count) >= AF_LEVEL);

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= datain;
    end
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_ok) begin
        wp <= (wp == LAST_IDX) ? '0 : wp + 1'b1;
      end
      if (rd_ok) begin
        rp <= (rp == LAST_IDX) ? '0 : rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataout   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_ok;
      if (rd_ok) begin
        dataout <= mem[rp];
      end
    end
  end

  // Setting an error flag takes priority over clearing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && !wr_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_req && !rd_ok) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard bench for fifo_param at WIDTH=4, DEPTH=5.
module tb_fifo_param;

  localparam int W = 4;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] datain = '0;
  logic         clr_err = 1'b0;
  logic [W-1:0] dataout;
  logic         valid_out;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [2:0]   count;
  logic         overflow;
  logic         underflow;

  fifo_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .mode(mode), .datain(datain), .clr_err(clr_err),
    .dataout(dataout), .valid_out(valid_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_data = '0;
  logic         exp_valid = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  // Drive one command at the falling edge, update the model, and return
  // #1 after the following rising edge with inputs back at idle.
  task automatic step(input logic [1:0] m, input logic [W-1:0] d, input logic c);
    logic rd_ok, wr_ok;
    @(negedge clk);
    mode = m; datain = d; clr_err = c;
    rd_ok = m[1] && (sb.size() != 0);
    wr_ok = m[0] && ((sb.size() != D) || rd_ok);
    exp_valid = rd_ok;
    if (rd_ok) exp_data = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    if (m[0] && !wr_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (m[1] && !rd_ok) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    @(posedge clk);
    #1;
    mode = 2'b00; datain = '0; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete(); exp_data = '0; exp_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else passed++;
    checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010)
      $display("[TB] FAIL reset_flags: got %b expected 1010", {empty, full, almost_empty, almost_full}); else passed++;
    checks++; if ({valid_out, overflow, underflow} !== 3'b000)
      $display("[TB] FAIL reset_vld_err: got %b expected 000", {valid_out, overflow, underflow}); else passed++;
    checks++; if (dataout !== 4'h0) $display("[TB] FAIL reset_dataout: got %0h expected 0", dataout); else passed++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      step(2'b01, W'(i), 1'b0);
      checks++; if (count !== 3'(i)) $display("[TB] FAIL fill_count: got %0d expected %0d", count, i); else passed++;
      checks++; if ({full, almost_full, almost_empty, empty} !== {i == D, i >= 4, i <= 1, 1'b0})
        $display("[TB] FAIL fill_flags: got %b expected %b", {full, almost_full, almost_empty, empty},
                 {i == D, i >= 4, i <= 1, 1'b0}); else passed++;
      checks++; if (overflow !== 1'b0) $display("[TB] FAIL fill_overflow: got %b expected 0", overflow); else passed++;
    end
  endtask

  task automatic test_overflow_drain();
    step(2'b01, 4'h6, 1'b0);
    checks++; if (overflow !== m_ovf) $display("[TB] FAIL ovf_flag: got %b expected %b", overflow, m_ovf); else passed++;
    checks++; if (count !== 3'(sb.size())) $display("[TB] FAIL ovf_count: got %0d expected %0d", count, sb.size()); else passed++;
    for (int i = 0; i < D; i++) begin
      step(2'b10, '0, 1'b0);
      checks++; if (dataout !== exp_data) $display("[TB] FAIL drain_data: got %0h expected %0h", dataout, exp_data); else passed++;
      checks++; if (valid_out !== 1'b1) $display("[TB] FAIL drain_valid: got %b expected 1", valid_out); else passed++;
    end
    checks++; if (empty !== 1'b1) $display("[TB] FAIL drain_empty: got %b expected 1", empty); else passed++;
    step(2'b00, '0, 1'b0);
    checks++; if (valid_out !== 1'b0) $display("[TB] FAIL valid_drop: got %b expected 0", valid_out); else passed++;
  endtask

  task automatic test_underflow();
    step(2'b10, '0, 1'b0);
    checks++; if (underflow !== 1'b1) $display("[TB] FAIL unf_set: got %b expected 1", underflow); else passed++;
    checks++; if (valid_out !== 1'b0) $display("[TB] FAIL unf_valid: got %b expected 0", valid_out); else passed++;
    checks++; if (dataout !== exp_data) $display("[TB] FAIL unf_hold: got %0h expected %0h", dataout, exp_data); else passed++;
    step(2'b00, '0, 1'b1);
    checks++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL clr_err: got %b expected 00", {overflow, underflow}); else passed++;
    step(2'b10, '0, 1'b1);
    checks++; if (underflow !== m_unf) $display("[TB] FAIL set_wins: got %b expected %b", underflow, m_unf); else passed++;
    step(2'b00, '0, 1'b1);
  endtask

  task automatic test_simul_empty();
    step(2'b11, 4'hA, 1'b0);
    checks++; if ({valid_out, underflow} !== 2'b01) $display("[TB] FAIL rw_empty_vu: got %b expected 01", {valid_out, underflow}); else passed++;
    checks++; if (count !== 3'd1) $display("[TB] FAIL rw_empty_count: got %0d expected 1", count); else passed++;
    step(2'b10, '0, 1'b1);
    checks++; if (dataout !== exp_data) $display("[TB] FAIL rw_empty_data: got %0h expected %0h", dataout, exp_data); else passed++;
  endtask

  task automatic test_simul_full();
    for (int i = 1; i <= D; i++) step(2'b01, W'(i), 1'b0);
    step(2'b11, 4'h9, 1'b0);
    checks++; if (dataout !== exp_data) $display("[TB] FAIL rw_full_data: got %0h expected %0h", dataout, exp_data); else passed++;
    checks++; if (count !== 3'd5) $display("[TB] FAIL rw_full_count: got %0d expected 5", count); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL rw_full_ovf: got %b expected 0", overflow); else passed++;
    while (sb.size() != 0) begin
      step(2'b10, '0, 1'b0);
      checks++; if (dataout !== exp_data) $display("[TB] FAIL rw_full_drain: got %0h expected %0h", dataout, exp_data); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] vals [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    apply_reset();
    for (int i = 0; i < 3; i++) step(2'b01, W'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) step(2'b10, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(2'b01, vals[i], 1'b0);
    checks++; if (count !== 3'd4) $display("[TB] FAIL wrap_count: got %0d expected 4", count); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(2'b10, '0, 1'b0);
      checks++; if (dataout !== exp_data) $display("[TB] FAIL wrap_data: got %0h expected %0h", dataout, exp_data); else passed++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(2'b01, W'(i + 3), 1'b0);
    step(2'b10, '0, 1'b0);
    #2;
    rst = 1'b1;
    sb.delete(); exp_data = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    checks++; if ({count, empty} !== {3'd0, 1'b1}) $display("[TB] FAIL arst_count: got %0d/%b expected 0/1", count, empty); else passed++;
    checks++; if (dataout !== 4'h0) $display("[TB] FAIL arst_dataout: got %0h expected 0", dataout); else passed++;
    #1;
    rst = 1'b0;
    step(2'b01, 4'h7, 1'b0);
    step(2'b10, '0, 1'b0);
    checks++; if (dataout !== exp_data) $display("[TB] FAIL arst_first: got %0h expected %0h", dataout, exp_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_simul_empty();
    test_simul_full();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
